tsv_frame_rx: RTL and testbench
===============================

// Module: tsv_frame_rx
// PURPOSE
// - Deserializer for the 1-bit inter-layer TSV link; sits directly upstream of the chip-ID sort/self-test FSM and drives its 32-bit data_in.
// - Hunts for a valid ID frame, locks frame alignment, then delivers one 32-bit word per 32 received bits.
// - Tracks sync loss and link idle time, so the sort FSM only ever sees aligned, checked frames.
// - Frame format, shifted MSB first: [31:30] type (must be 2'b10), [29:16] payload (power state / chip ids), [15:0] SYNC_WORD.
// PARAMETERS
// - SYNC_WORD  16'hBEAF  trailer every frame must carry
// - MISS_MAX   3         consecutive bad frames in LOCK before falling back to HUNT (>=1)
// - TIMEOUT    1023      clk cycles with no rx_vld in LOCK before falling back to HUNT (<2^10)
// PORTS
// - clk         in   1   clock
// - rst_n       in   1   reset; asynchronous, active-low
// - clear       in   1   sync clear: back to HUNT, frame_cnt=0
// - rx_vld      in   1   rx_bit is valid this cycle
// - rx_bit      in   1   serial data bit, MSB of frame first
// - frame_data  out  32  last accepted frame; held until the next accept
// - frame_vld   out  1   1-cycle pulse: new frame_data
// - locked      out  1   1 while in LOCK
// - sync_err    out  1   1-cycle pulse: bad frame in LOCK, or timeout
// - par_err     out  1   1-cycle pulse: parity failure (tied 0 without macro)
// - frame_cnt   out  8   accepted frames; saturates at 8'hFF
// BEHAVIOUR
// - Reset: state=HUNT; all outputs, shift reg, bit_cnt, miss_cnt, idle_cnt = 0.
// - Each rx_vld cycle: sreg <= {sreg[30:0], rx_bit}. Let nxt be the post-shift value; "good" = nxt[31:30]==2'b10 && nxt[15:0]==SYNC_WORD.
// - HUNT:
//   - Checked on every rx_vld bit (sliding window); bit_cnt is ignored.
//   - good -> accept, go to LOCK, bit_cnt=0, miss_cnt=0.
//   - Not good -> no output.
// - LOCK:
//   - Each rx_vld: bit_cnt++ (5-bit, wraps). Frame boundary = the rx_vld on which bit_cnt==31.
//   - Boundary and good -> accept, miss_cnt=0.
//   - Boundary and not good -> sync_err pulse, miss_cnt++. If miss_cnt reaches MISS_MAX -> HUNT, miss_cnt=0.
//   - idle_cnt: cleared on each rx_vld, else incremented. Reaching TIMEOUT -> HUNT plus one sync_err pulse.
// - Accept: frame_data<=nxt, frame_vld=1, frame_cnt++ (saturating). Occurs the cycle after the bit is sampled (1-cycle latency).
// - locked is registered: it rises with the first frame_vld and falls the cycle after the HUNT transition.
// - clear has priority over everything in the same cycle: accept suppressed, state=HUNT, frame_cnt=0, counters=0. frame_data is kept.
// - rst_n mid-frame: partial bits are discarded; the bench must see HUNT with no spurious pulse after release.
// - rx_vld gaps inside a frame are legal; bit alignment is preserved while idle_cnt<TIMEOUT.
// CONFIGURATION
// - TSV_RX_PARITY_EN defined:
//   - good additionally requires even parity over all 32 bits of nxt.
//   - Parity fail in HUNT: par_err pulse, stay in HUNT.
//   - Parity fail in LOCK: par_err plus sync_err pulse, counts as a miss.
// - TSV_RX_PARITY_EN undefined: no parity check; par_err is constant 0.
// TESTING
// - T1: rst, then 32 consecutive rx_vld bits of 32'h8001_BEAF -> frame_vld 1 cycle after bit 32, frame_data=32'h8001BEAF, locked=1, frame_cnt=1 (both configs).
// - T2: 7 random bits, then 32'h8001_BEAF -> lock at the correct alignment; next 32 bits 32'h8001_BEAF -> second frame_vld exactly 32 bits later, frame_cnt=2.
// - T3: locked, then 3 frames with trailer 16'hDEAD -> 3 sync_err pulses, no frame_vld, locked=0 after the third; the next good frame relocks.
// - T4: locked, rx_vld held low 1023 cycles -> sync_err pulse and locked=0; a gap of 1022 cycles keeps lock.
// - T5: 32'h8005_BEAF (odd parity) -> with TSV_RX_PARITY_EN: par_err pulse, no lock; without: accepted, locked=1.
// - T6: clear asserted on the same cycle as the 32nd bit of a good frame -> no frame_vld, frame_cnt=0, locked=0; rst_n pulsed mid-frame -> HUNT, all outputs 0.

Source files
------------

// File: rtl/tsv_frame_rx.sv
// ---------------------------------------------------------------------------
// tsv_frame_rx
// Deserializer for the 1-bit inter-layer TSV link. It hunts for a valid ID
// frame on a sliding window, locks frame alignment, then delivers one 32-bit
// word per 32 received bits to the downstream chip-ID sort FSM. It also tracks
// sync loss (bad frames while locked) and link idle time (timeout).
//
// Frame format (shifted MSB first):
//   [31:30] type, must be 2'b10
//   [29:16] payload
//   [15:0]  SYNC_WORD trailer
//
// Handshake: rx_bit is consumed on every rising clk edge where rx_vld is 1;
// there is no backpressure. frame_vld is a 1-cycle pulse qualifying a new
// frame_data value, which is then held until the next accepted frame.
//
// Optional feature: define TSV_RX_PARITY_EN to require even parity over all
// 32 frame bits. Without it, par_err is constant 0.
//
// Ports:
//   clk        in   1   clock
//   rst_n      in   1   asynchronous active-low reset
//   clear      in   1   synchronous clear: back to HUNT, frame_cnt=0
//   rx_vld     in   1   rx_bit valid this cycle
//   rx_bit     in   1   serial data, MSB of frame first
//   frame_data out  32  last accepted frame
//   frame_vld  out  1   pulse: new frame_data
//   locked     out  1   1 while in LOCK (registered copy of the FSM state)
//   sync_err   out  1   pulse: bad frame in LOCK, or idle timeout
//   par_err    out  1   pulse: parity failure
//   frame_cnt  out  8   accepted frames, saturating at 8'hFF
// ---------------------------------------------------------------------------
module tsv_frame_rx #(
  parameter logic [15:0] SYNC_WORD = 16'hBEAF,
  parameter int          MISS_MAX  = 3,
  parameter int          TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        rx_vld,
  input  logic        rx_bit,
  output logic [31:0] frame_data,
  output logic        frame_vld,
  output logic        locked,
  output logic        sync_err,
  output logic        par_err,
  output logic [7:0]  frame_cnt
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [7:0] MISS_LIM = 8'(MISS_MAX);
  localparam logic [9:0] TO_LIM   = 10'(TIMEOUT);

  state_t      state;
  logic [31:0] sreg;
  logic [4:0]  bit_cnt;
  logic [7:0]  miss_cnt;
  logic [9:0]  idle_cnt;

  logic [31:0] nxt;
  logic        fmt_ok;
  logic        par_bad;
  logic        good;
  logic        boundary;
  logic        accept;

  // Window as it will look once the current bit has been shifted in.
  assign nxt    = {sreg[30:0], rx_bit};
  assign fmt_ok = (nxt[31:30] == 2'b10) && (nxt[15:0] == SYNC_WORD);

`ifdef TSV_RX_PARITY_EN
  assign par_bad = ^nxt;
`else
  assign par_bad = 1'b0;
`endif

  assign good     = fmt_ok && !par_bad;
  // HUNT checks every bit; LOCK only checks on the 32nd bit of a frame.
  assign boundary = (state == HUNT) || (bit_cnt == 5'd31);
  assign accept   = !clear && rx_vld && boundary && good;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      sreg       <= '0;
      bit_cnt    <= '0;
      miss_cnt   <= '0;
      idle_cnt   <= '0;
      frame_data <= '0;
      frame_vld  <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
      par_err    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_vld <= 1'b0;
      sync_err  <= 1'b0;
      par_err   <= 1'b0;

      if (accept) begin
        frame_data <= nxt;
        frame_vld  <= 1'b1;
        if (frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
      end

      if (clear) begin
        // Clear wins over everything; frame_data is deliberately kept.
        state     <= HUNT;
        locked    <= 1'b0;
        sreg      <= '0;
        bit_cnt   <= '0;
        miss_cnt  <= '0;
        idle_cnt  <= '0;
        frame_cnt <= '0;
      end else begin
        case (state)
          HUNT: begin
            idle_cnt <= '0;
            if (rx_vld) begin
              sreg <= nxt;
              if (good) begin
                state    <= LOCK;
                locked   <= 1'b1;
                bit_cnt  <= '0;
                miss_cnt <= '0;
              end else if (fmt_ok && par_bad) begin
                // Only report parity on an otherwise well-formed window,
                // otherwise the sliding search would flag every other bit.
                par_err <= 1'b1;
              end
            end
          end

          LOCK: begin
            if (rx_vld) begin
              sreg     <= nxt;
              idle_cnt <= '0;
              bit_cnt  <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd31) begin
                if (good) begin
                  miss_cnt <= '0;
                end else begin
                  sync_err <= 1'b1;
                  par_err  <= par_bad;
                  if (miss_cnt == MISS_LIM - 8'd1) begin
                    state    <= HUNT;
                    locked   <= 1'b0;
                    miss_cnt <= '0;
                  end else begin
                    miss_cnt <= miss_cnt + 8'd1;
                  end
                end
              end
            end else if (idle_cnt == TO_LIM - 10'd1) begin
              // This idle cycle is the TIMEOUT-th in a row.
              state    <= HUNT;
              locked   <= 1'b0;
              sync_err <= 1'b1;
              idle_cnt <= '0;
              bit_cnt  <= '0;
              miss_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 10'd1;
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tsv_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_tsv_frame_rx
// Directed bench for tsv_frame_rx. Inputs change on the falling clk edge and
// outputs are checked on the falling edge after the sampling rising edge.
// A small monitor counts output pulses so gaps can be shown to be pulse-free.
// ---------------------------------------------------------------------------
module tb_tsv_frame_rx;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        rx_vld;
  logic        rx_bit;
  logic [31:0] frame_data;
  logic        frame_vld;
  logic        locked;
  logic        sync_err;
  logic        par_err;
  logic [7:0]  frame_cnt;

  int tests;
  int fails;
  int fv_cnt;
  int se_cnt;
  int pe_cnt;
  int fv0;
  int se0;

  tsv_frame_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .rx_vld     (rx_vld),
    .rx_bit     (rx_bit),
    .frame_data (frame_data),
    .frame_vld  (frame_vld),
    .locked     (locked),
    .sync_err   (sync_err),
    .par_err    (par_err),
    .frame_cnt  (frame_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_vld) fv_cnt++;
      if (sync_err)  se_cnt++;
      if (par_err)   pe_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_bit(input logic b);
    rx_vld = 1'b1;
    rx_bit = b;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
    rx_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    tests  = 0;
    fails  = 0;
    fv_cnt = 0;
    se_cnt = 0;
    pe_cnt = 0;
    rst_n  = 1'b0;
    clear  = 1'b0;
    rx_vld = 1'b0;
    rx_bit = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_frame_data", frame_data, 32'h0);
    check("rst_frame_vld",  {31'b0, frame_vld}, 32'h0);
    check("rst_locked",     {31'b0, locked},    32'h0);
    check("rst_sync_err",   {31'b0, sync_err},  32'h0);
    check("rst_par_err",    {31'b0, par_err},   32'h0);
    check("rst_frame_cnt",  {24'b0, frame_cnt}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: first good frame locks
    send_word(32'h8001_BEAF);
    check("t1_frame_vld",  {31'b0, frame_vld}, 32'h1);
    check("t1_frame_data", frame_data, 32'h8001_BEAF);
    check("t1_locked",     {31'b0, locked},    32'h1);
    check("t1_frame_cnt",  {24'b0, frame_cnt}, 32'h1);
    idle(1);
    check("t1_vld_pulse",  {31'b0, frame_vld}, 32'h0);

    // T2: random prefix, lock, then a second frame exactly 32 bits later
    do_clear();
    check("t2_clr_locked", {31'b0, locked},    32'h0);
    check("t2_clr_cnt",    {24'b0, frame_cnt}, 32'h0);
    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
    send_word(32'h8001_BEAF);
    check("t2_lock_vld",   {31'b0, frame_vld}, 32'h1);
    check("t2_lock_cnt",   {24'b0, frame_cnt}, 32'h1);
    #1;
    fv0 = fv_cnt;
    @(negedge clk);
    send_word(32'h8001_BEAF);
    check("t2_second_vld", {31'b0, frame_vld}, 32'h1);
    check("t2_second_cnt", {24'b0, frame_cnt}, 32'h2);
    #1;
    check("t2_one_pulse",  32'(fv_cnt - fv0), 32'h1);

    // T3: three bad trailers drop lock, next good frame relocks
    @(negedge clk);
    fv0 = fv_cnt;
    se0 = se_cnt;
    for (int k = 0; k < 3; k++) begin
      send_word(32'h8001_DEAD);
      check($sformatf("t3_sync_err%0d", k), {31'b0, sync_err}, 32'h1);
      check($sformatf("t3_locked%0d", k), {31'b0, locked}, (k == 2) ? 32'h0 : 32'h1);
    end
    #1;
    check("t3_no_vld",     32'(fv_cnt - fv0), 32'h0);
    check("t3_err_pulses", 32'(se_cnt - se0), 32'h3);
    @(negedge clk);
    send_word(32'h8001_BEAF);
    check("t3_relock_vld", {31'b0, frame_vld}, 32'h1);
    check("t3_relock",     {31'b0, locked},    32'h1);
    check("t3_cnt",        {24'b0, frame_cnt}, 32'h3);

    // T4: 1022-cycle gap keeps lock and alignment; 1023 times out
    #1;
    se0 = se_cnt;
    @(negedge clk);
    idle(1021);
    check("t4_gap_locked", {31'b0, locked}, 32'h1);
    send_word(32'h8001_BEAF);
    check("t4_gap_vld",    {31'b0, frame_vld}, 32'h1);
    check("t4_gap_cnt",    {24'b0, frame_cnt}, 32'h4);
    idle(1022);
    check("t4_pre_to_locked", {31'b0, locked}, 32'h1);
    check("t4_pre_to_err",    32'(se_cnt - se0), 32'h0);
    idle(1);
    check("t4_to_sync_err", {31'b0, sync_err}, 32'h1);
    check("t4_to_locked",   {31'b0, locked},   32'h0);
    idle(1);
    check("t4_to_pulse",    {31'b0, sync_err}, 32'h0);

    // T5: odd-parity frame
    do_clear();
    send_word(32'h8005_BEAF);
`ifdef TSV_RX_PARITY_EN
    check("t5_par_err", {31'b0, par_err},   32'h1);
    check("t5_vld",     {31'b0, frame_vld}, 32'h0);
    check("t5_locked",  {31'b0, locked},    32'h0);
    check("t5_cnt",     {24'b0, frame_cnt}, 32'h0);
`else
    check("t5_par_err", {31'b0, par_err},   32'h0);
    check("t5_vld",     {31'b0, frame_vld}, 32'h1);
    check("t5_locked",  {31'b0, locked},    32'h1);
    check("t5_cnt",     {24'b0, frame_cnt}, 32'h1);
`endif

    // T6: clear on the 32nd bit of a good frame suppresses the accept
    idle(1);
    do_clear();
    w = 32'h8001_BEAF;
    for (int i = 31; i >= 0; i--) begin
      if (i == 0) clear = 1'b1;
      send_bit(w[i]);
    end
    clear  = 1'b0;
    rx_vld = 1'b0;
    check("t6_clr_vld",    {31'b0, frame_vld}, 32'h0);
    check("t6_clr_cnt",    {24'b0, frame_cnt}, 32'h0);
    check("t6_clr_locked", {31'b0, locked},    32'h0);
`ifdef TSV_RX_PARITY_EN
    check("t6_clr_data",   frame_data, 32'h8001_BEAF);
`else
    check("t6_clr_data",   frame_data, 32'h8005_BEAF);
`endif

    // T6b: reset in the middle of a frame
    for (int i = 31; i >= 16; i--) send_bit(w[i]);
    rx_vld = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("t6_rst_data",   frame_data, 32'h0);
    check("t6_rst_locked", {31'b0, locked},    32'h0);
    check("t6_rst_cnt",    {24'b0, frame_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    fv0 = fv_cnt;
    se0 = se_cnt;
    @(negedge clk);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
    idle(3);
    #1;
    check("t6_rst_no_vld", 32'(fv_cnt - fv0), 32'h0);
    check("t6_rst_no_err", 32'(se_cnt - se0), 32'h0);
    check("t6_rst_hunt",   {31'b0, locked},   32'h0);
    @(negedge clk);
    send_word(32'h8001_BEAF);
    check("t6_relock_vld", {31'b0, frame_vld}, 32'h1);
    check("t6_relock_cnt", {24'b0, frame_cnt}, 32'h1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
